dram_access_arbiter: RTL and testbench

// Shares one single-port 8-bit sync data RAM (1-cycle read latency) between the Raspberry Pi host bus and the CNT CPU data port.

---
 rtl/dram_arb_pkg.sv | 6 +
 rtl/dram_access_arbiter_if.sv | 30 +++
 rtl/pi_host_port.sv | 70 +++++++
 rtl/dram_access_arbiter.sv | 95 +++++++++
 tb/tb_dram_access_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/dram_arb_pkg.sv
// dram_arb_pkg: shared types for the DRAM access arbiter.
package dram_arb_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, CAPTURE} state_e;
    typedef enum logic {REQ_PI, REQ_CPU} req_e;
    localparam int WAIT_W = 4;
endpackage

// File: rtl/dram_access_arbiter_if.sv
// dram_access_arbiter_if: Pi host bus, CPU data port and data-RAM port bundle.
interface dram_access_arbiter_if #(parameter int AW = 8, parameter int DW = 8);
    logic          com_flag;
    logic          pi_strobe;
    logic          pi_wr;
    logic          pi_ad;
    logic [DW-1:0] pi_din;
    logic [DW-1:0] pi_dout;
    logic          pi_rvalid;
    logic          pi_busy;
    logic          pi_err;
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic          cpu_ack;
    logic [DW-1:0] cpu_rdata;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_din;
    logic [DW-1:0] ram_dout;
    modport master (
        output com_flag, pi_strobe, pi_wr, pi_ad, pi_din, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_dout,
        input  pi_dout, pi_rvalid, pi_busy, pi_err, cpu_ack, cpu_rdata, ram_we, ram_addr, ram_din
    );
    modport slave (
        input  com_flag, pi_strobe, pi_wr, pi_ad, pi_din, cpu_req, cpu_we, cpu_addr, cpu_wdata, ram_dout,
        output pi_dout, pi_rvalid, pi_busy, pi_err, cpu_ack, cpu_rdata, ram_we, ram_addr, ram_din
    );
endinterface

// File: rtl/pi_host_port.sv
// pi_host_port: Pi strobe decode, auto-incrementing address, single pending request and read return.
module pi_host_port #(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int AUTO_INC = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          strobe_i,
    input  logic          wr_i,
    input  logic          ad_i,
    input  logic [DW-1:0] din_i,
    input  logic          grant_i,
    input  logic          done_i,
    input  logic          cap_i,
    input  logic [DW-1:0] rdata_i,
    output logic          req_o,
    output logic          req_we_o,
    output logic [AW-1:0] req_addr_o,
    output logic [DW-1:0] req_data_o,
    output logic [DW-1:0] dout_o,
    output logic          rvalid_o,
    output logic          busy_o,
    output logic          err_o
);
    logic [AW-1:0] addr_q, req_addr_q;
    logic [DW-1:0] req_data_q, dout_q;
    logic          pend_q, busy_q, we_q, err_q, rvalid_q, held_q;
    logic          ld, rq, acc;

    assign ld  = strobe_i & wr_i & ad_i;
    assign rq  = strobe_i & ~(wr_i & ad_i);
    assign acc = rq & ~busy_q;

    // held_q: an address loaded mid-transfer must not be bumped by that transfer's completion
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            addr_q     <= '0;
            req_addr_q <= '0;
            req_data_q <= '0;
            dout_q     <= '0;
            pend_q     <= 1'b0;
            busy_q     <= 1'b0;
            we_q       <= 1'b0;
            err_q      <= 1'b0;
            rvalid_q   <= 1'b0;
            held_q     <= 1'b0;
        end else begin
            addr_q     <= ld ? din_i : (done_i && AUTO_INC != 0 && !held_q) ? addr_q + 1'b1 : addr_q;
            held_q     <= ld ? (busy_q & ~done_i) : done_i ? 1'b0 : held_q;
            pend_q     <= acc ? 1'b1 : grant_i ? 1'b0 : pend_q;
            busy_q     <= acc ? 1'b1 : done_i ? 1'b0 : busy_q;
            we_q       <= acc ? wr_i : we_q;
            req_addr_q <= acc ? addr_q : req_addr_q;
            req_data_q <= acc ? din_i : req_data_q;
            err_q      <= err_q | (rq & busy_q);
            rvalid_q   <= cap_i;
            dout_q     <= cap_i ? rdata_i : dout_q;
        end
    end

    assign req_o      = pend_q;
    assign req_we_o   = we_q;
    assign req_addr_o = req_addr_q;
    assign req_data_o = req_data_q;
    assign dout_o     = dout_q;
    assign rvalid_o   = rvalid_q;
    assign busy_o     = busy_q;
    assign err_o      = err_q;
endmodule

// File: rtl/dram_access_arbiter.sv
// dram_access_arbiter: shares one sync single-port data RAM between the Pi host bus and the CPU data port.
module dram_access_arbiter
    import dram_arb_pkg::*;
#(
    parameter int AW       = 8,
    parameter int DW       = 8,
    parameter int AUTO_INC = 1,
    parameter int MAX_WAIT = 15
) (
    input logic                 gclk,
    input logic                 rst,
    dram_access_arbiter_if.slave bus
);
    state_e        state_q, state_d;
    req_e          own_q, own_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic          ram_we_q, cpu_ack_q;
    logic [AW-1:0] ram_addr_q;
    logic [DW-1:0] ram_din_q, cpu_rdata_q;
    logic          pi_req, pi_we;
    logic [AW-1:0] pi_addr;
    logic [DW-1:0] pi_data;
    logic          both, win_cpu, grant, fin, cap;

    pi_host_port #(.AW(AW), .DW(DW), .AUTO_INC(AUTO_INC)) u_pi (
        .clk       (gclk),
        .rst       (rst),
        .strobe_i  (bus.pi_strobe),
        .wr_i      (bus.pi_wr),
        .ad_i      (bus.pi_ad),
        .din_i     (bus.pi_din),
        .grant_i   (grant & ~win_cpu),
        .done_i    (fin & (own_q == REQ_PI)),
        .cap_i     (cap & (own_q == REQ_PI)),
        .rdata_i   (bus.ram_dout),
        .req_o     (pi_req),
        .req_we_o  (pi_we),
        .req_addr_o(pi_addr),
        .req_data_o(pi_data),
        .dout_o    (bus.pi_dout),
        .rvalid_o  (bus.pi_rvalid),
        .busy_o    (bus.pi_busy),
        .err_o     (bus.pi_err)
    );

    // com_flag==1 means Pi owns priority; a saturated wait counter hands the tie to the other side
    assign both    = pi_req & bus.cpu_req;
    assign win_cpu = both ? (bus.com_flag == (wait_q == WAIT_W'(MAX_WAIT))) : bus.cpu_req;
    assign grant   = (state_q == IDLE) && (pi_req || bus.cpu_req);
    assign cap     = state_q == CAPTURE;
    assign fin     = (state_q == ACCESS && ram_we_q) || cap;

    always_comb begin
        state_d = state_q;
        own_d   = own_q;
        wait_d  = wait_q;
        if (grant) begin
            state_d = ACCESS;
            own_d   = win_cpu ? REQ_CPU : REQ_PI;
            wait_d  = (win_cpu == bus.com_flag) ? '0 : both ? wait_q + 1'b1 : wait_q;
        end else if (state_q == ACCESS) begin
            state_d = ram_we_q ? IDLE : CAPTURE;
        end else if (state_q == CAPTURE) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge gclk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            own_q       <= REQ_PI;
            wait_q      <= '0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_din_q   <= '0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            own_q       <= own_d;
            wait_q      <= wait_d;
            ram_we_q    <= grant && (win_cpu ? bus.cpu_we : pi_we);
            ram_addr_q  <= grant ? (win_cpu ? bus.cpu_addr : pi_addr) : ram_addr_q;
            ram_din_q   <= grant ? (win_cpu ? bus.cpu_wdata : pi_data) : ram_din_q;
            cpu_ack_q   <= fin && own_q == REQ_CPU;
            cpu_rdata_q <= (cap && own_q == REQ_CPU) ? bus.ram_dout : cpu_rdata_q;
        end
    end

    assign bus.ram_we    = ram_we_q;
    assign bus.ram_addr  = ram_addr_q;
    assign bus.ram_din   = ram_din_q;
    assign bus.cpu_ack   = cpu_ack_q;
    assign bus.cpu_rdata = cpu_rdata_q;
endmodule

// File: tb/tb_dram_access_arbiter.sv
// tb_dram_access_arbiter: directed checks of the arbiter against a behavioural sync RAM.
module tb_dram_access_arbiter;
    logic gclk = 1'b0;
    logic rst  = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    logic [7:0] mem [256];
    logic mem_ok = 1'b0;

    dram_access_arbiter_if bus ();
    dram_access_arbiter dut (.gclk(gclk), .rst(rst), .bus(bus));

    always #5 gclk = ~gclk;

    // RAM content starts as addr ^ 0x5A so reads of untouched words are predictable
    always @(posedge gclk) begin
        if (!mem_ok) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'h5A;
            mem_ok <= 1'b1;
        end else if (bus.ram_we) begin
            mem[bus.ram_addr] <= bus.ram_din;
        end
        bus.ram_dout <= mem[bus.ram_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step;
        @(posedge gclk);
        #1;
    endtask

    task automatic pi_strobe(input logic wr, input logic ad, input logic [7:0] d);
        bus.pi_strobe = 1'b1;
        bus.pi_wr     = wr;
        bus.pi_ad     = ad;
        bus.pi_din    = d;
        step;
        bus.pi_strobe = 1'b0;
    endtask

    task automatic pi_wait_idle;
        int n = 0;
        while (bus.pi_busy && n < 50) begin
            step;
            n++;
        end
        check("pi_idle_timeout", 32'(n < 50), 1);
    endtask

    task automatic pi_wait_rvalid;
        int n = 0;
        while (!bus.pi_rvalid && n < 50) begin
            step;
            n++;
        end
        check("pi_rvalid_timeout", 32'(n < 50), 1);
    endtask

    task automatic cpu_xfer(input logic we, input logic [7:0] a, input logic [7:0] d, output int n);
        bus.cpu_req   = 1'b1;
        bus.cpu_we    = we;
        bus.cpu_addr  = a;
        bus.cpu_wdata = d;
        n = 0;
        do begin
            step;
            n++;
        end while (!bus.cpu_ack && n < 20);
        bus.cpu_req = 1'b0;
    endtask

    initial begin
        int n;
        int acks;
        bus.com_flag  = 1'b0;
        bus.pi_strobe = 1'b0;
        bus.pi_wr     = 1'b0;
        bus.pi_ad     = 1'b0;
        bus.pi_din    = '0;
        bus.cpu_req   = 1'b0;
        bus.cpu_we    = 1'b0;
        bus.cpu_addr  = '0;
        bus.cpu_wdata = '0;
        step;
        step;
        check("rst_ram_we", 32'(bus.ram_we), 0);
        check("rst_ram_addr", 32'(bus.ram_addr), 0);
        check("rst_cpu_ack", 32'(bus.cpu_ack), 0);
        check("rst_pi_busy", 32'(bus.pi_busy), 0);
        check("rst_pi_err", 32'(bus.pi_err), 0);
        check("rst_pi_dout", 32'(bus.pi_dout), 0);
        rst = 1'b0;
        step;

        // CPU write then read, cycle-exact
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h10; bus.cpu_wdata = 8'hA5;
        step;
        check("cw_ram_we", 32'(bus.ram_we), 1);
        check("cw_ram_addr", 32'(bus.ram_addr), 32'h10);
        check("cw_ram_din", 32'(bus.ram_din), 32'hA5);
        check("cw_ack_early", 32'(bus.cpu_ack), 0);
        step;
        check("cw_ack", 32'(bus.cpu_ack), 1);
        check("cw_ram_we_clr", 32'(bus.ram_we), 0);
        check("cw_mem", 32'(mem[8'h10]), 32'hA5);
        bus.cpu_we = 1'b0;
        cpu_xfer(1'b0, 8'h10, 8'h00, n);
        check("cr_latency", n, 3);
        check("cr_rdata", 32'(bus.cpu_rdata), 32'hA5);

        // Pi address load, two writes across the wrap, two reads
        pi_strobe(1'b1, 1'b1, 8'hFE);
        check("pi_ld_busy", 32'(bus.pi_busy), 0);
        pi_strobe(1'b1, 1'b0, 8'h11);
        check("pi_busy_set", 32'(bus.pi_busy), 1);
        pi_wait_idle;
        check("pi_mem_fe", 32'(mem[8'hFE]), 32'h11);
        pi_strobe(1'b1, 1'b0, 8'h22);
        pi_wait_idle;
        check("pi_mem_ff", 32'(mem[8'hFF]), 32'h22);
        pi_strobe(1'b0, 1'b0, 8'h00);
        pi_wait_rvalid;
        check("pi_rd0", 32'(bus.pi_dout), 32'h5A);
        check("pi_rd0_busy", 32'(bus.pi_busy), 0);
        pi_strobe(1'b0, 1'b1, 8'h00);
        pi_wait_rvalid;
        check("pi_rd1", 32'(bus.pi_dout), 32'h5B);
        step;
        check("pi_rvalid_pulse", 32'(bus.pi_rvalid), 0);

        // Pi owner: simultaneous requests, Pi first then CPU
        bus.com_flag = 1'b1;
        pi_strobe(1'b1, 1'b1, 8'h40);
        pi_strobe(1'b1, 1'b0, 8'h77);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h41; bus.cpu_wdata = 8'h88;
        step;
        check("p1_first_addr", 32'(bus.ram_addr), 32'h40);
        check("p1_first_din", 32'(bus.ram_din), 32'h77);
        step;
        check("p1_pi_done", 32'(bus.pi_busy), 0);
        step;
        check("p1_second_addr", 32'(bus.ram_addr), 32'h41);
        check("p1_second_we", 32'(bus.ram_we), 1);
        step;
        check("p1_cpu_ack", 32'(bus.cpu_ack), 1);
        bus.cpu_req = 1'b0;

        // CPU owner: simultaneous requests, CPU first then Pi
        bus.com_flag = 1'b0;
        pi_strobe(1'b1, 1'b1, 8'h50);
        pi_strobe(1'b1, 1'b0, 8'h99);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h51; bus.cpu_wdata = 8'h66;
        step;
        check("p0_first_addr", 32'(bus.ram_addr), 32'h51);
        step;
        check("p0_cpu_ack", 32'(bus.cpu_ack), 1);
        bus.cpu_req = 1'b0;
        step;
        check("p0_second_addr", 32'(bus.ram_addr), 32'h50);
        check("p0_second_din", 32'(bus.ram_din), 32'h99);
        step;
        check("p0_pi_done", 32'(bus.pi_busy), 0);
        check("p0_mem_50", 32'(mem[8'h50]), 32'h99);
        check("p0_mem_51", 32'(mem[8'h51]), 32'h66);

        // Starvation guard: CPU holds its request, Pi forced in after 15 losing IDLE cycles
        pi_strobe(1'b1, 1'b1, 8'h60);
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h70; bus.cpu_wdata = 8'h01;
        pi_strobe(1'b1, 1'b0, 8'hC3);
        acks = 0;
        n = 0;
        while (bus.pi_busy && n < 100) begin
            step;
            n++;
            acks += int'(bus.cpu_ack);
        end
        bus.cpu_req = 1'b0;
        check("starve_timeout", 32'(n < 100), 1);
        check("starve_cpu_acks", acks, 16);
        check("starve_pi_mem", 32'(mem[8'h60]), 32'hC3);

        // Strobes while busy: data strobe dropped with sticky error, address load still applies
        step;
        pi_strobe(1'b1, 1'b1, 8'h80);
        pi_strobe(1'b0, 1'b0, 8'h00);
        pi_strobe(1'b1, 1'b0, 8'h34);
        check("err_set", 32'(bus.pi_err), 1);
        pi_strobe(1'b1, 1'b1, 8'h90);
        pi_wait_rvalid;
        check("err_rd", 32'(bus.pi_dout), 32'hDA);
        pi_strobe(1'b1, 1'b0, 8'h56);
        pi_wait_idle;
        check("err_ld_mem", 32'(mem[8'h90]), 32'h56);
        check("err_drop_80", 32'(mem[8'h80]), 32'hDA);
        check("err_drop_81", 32'(mem[8'h81]), 32'hDB);
        check("err_sticky", 32'(bus.pi_err), 1);

        // Async reset in the middle of a CPU write
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 8'h20; bus.cpu_wdata = 8'hEE;
        step;
        check("ar_we_before", 32'(bus.ram_we), 1);
        #1 rst = 1'b1;
        #1;
        check("ar_ram_we", 32'(bus.ram_we), 0);
        check("ar_ram_addr", 32'(bus.ram_addr), 0);
        check("ar_ram_din", 32'(bus.ram_din), 0);
        check("ar_pi_err", 32'(bus.pi_err), 0);
        check("ar_pi_dout", 32'(bus.pi_dout), 0);
        check("ar_cpu_rdata", 32'(bus.cpu_rdata), 0);
        bus.cpu_req = 1'b0;
        step;
        rst = 1'b0;
        check("ar_no_write", 32'(mem[8'h20]), 32'h7A);
        step;
        cpu_xfer(1'b0, 8'h10, 8'h00, n);
        check("ar_cr_latency", n, 3);
        check("ar_cr_rdata", 32'(bus.cpu_rdata), 32'hA5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
